// File: rtl/udp_responder_pkg.sv
// Shared types and constants for the UDP discovery responder.
// Optional statistics reply is enabled by UDP_RESPONDER_STATS_EN.
package udp_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_RSP,
    ST_FLUSH
  } state_t;

  localparam logic [7:0]  OP_DISCOVER  = 8'h11;
  localparam logic [7:0]  OP_STATS     = 8'h13;
  localparam logic [7:0]  RSP_DISCOVER = 8'h22;
  localparam logic [7:0]  RSP_STATS    = 8'h33;
  localparam logic [15:0] DEFAULT_PORT = 16'h9460;
  localparam int          STATS_BYTES  = 4;

endpackage

// File: rtl/udp_reply_serializer.sv
// Reply byte sequencer: byte index, byte mux and last-byte flag.
// Optional statistics reply is enabled by UDP_RESPONDER_STATS_EN.
module udp_reply_serializer
  import udp_responder_pkg::*;
#(
  parameter int                    NAME_LEN = 8,
  parameter logic [8*NAME_LEN-1:0] NAME     = "test1234"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        active_i,
  input  logic        ready_i,
  input  logic        stats_i,
  input  logic [31:0] stats_word_i,
  output logic [7:0]  data_o,
  output logic        last_o
);

  logic [4:0] idx_q;
  logic [4:0] idx_d;
  logic [7:0] name_byte;
  logic [7:0] stats_byte;

  always_comb begin
    idx_d = idx_q;
    if (start_i)
      idx_d = '0;
    else if (active_i && ready_i)
      idx_d = idx_q + 5'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  // Index 0 is the reply code; name bytes follow MSB first.
  always_comb begin
    name_byte = 8'h00;
    for (int k = 0; k < NAME_LEN; k++)
      if (idx_q == 5'(k + 1))
        name_byte = NAME[8*(NAME_LEN-1-k) +: 8];
  end

  always_comb begin
    stats_byte = 8'h00;
    case (idx_q)
      5'd1:    stats_byte = stats_word_i[31:24];
      5'd2:    stats_byte = stats_word_i[23:16];
      5'd3:    stats_byte = stats_word_i[15:8];
      5'd4:    stats_byte = stats_word_i[7:0];
      default: stats_byte = 8'h00;
    endcase
  end

  always_comb begin
    data_o = 8'h00;
    unique case (1'b1)
      idx_q == 5'd0:
        data_o = stats_i ? RSP_STATS : RSP_DISCOVER;
      idx_q != 5'd0 && stats_i:
        data_o = stats_byte;
      idx_q != 5'd0 && !stats_i:
        data_o = name_byte;
      default:
        data_o = 8'h00;
    endcase
  end

  assign last_o = stats_i ? (idx_q == 5'(STATS_BYTES))
                          : (idx_q == 5'(NAME_LEN));

endmodule

// File: rtl/udp_discovery_responder.sv
// Answers discover (and optionally stats) requests on one UDP port.
// Optional statistics reply is enabled by UDP_RESPONDER_STATS_EN.
module udp_discovery_responder
  import udp_responder_pkg::*;
#(
  parameter logic [15:0]           LISTEN_PORT = DEFAULT_PORT,
  parameter int                    NAME_LEN    = 8,
  parameter logic [8*NAME_LEN-1:0] NAME        = "test1234"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_cmd_valid,
  output logic        rx_cmd_ready,
  input  logic [31:0] rx_cmd_ip,
  input  logic [15:0] rx_cmd_src_port,
  input  logic [15:0] rx_cmd_dst_port,
  input  logic [15:0] rx_cmd_length,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  input  logic        rx_data_last,
  input  logic [7:0]  rx_data,
  output logic        tx_cmd_valid,
  input  logic        tx_cmd_ready,
  output logic [31:0] tx_cmd_ip,
  output logic [15:0] tx_cmd_src_port,
  output logic [15:0] tx_cmd_dst_port,
  output logic [15:0] tx_cmd_length,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        tx_data_last,
  output logic [7:0]  tx_data
`ifdef UDP_RESPONDER_STATS_EN
  ,
  output logic [15:0] stat_disc_count,
  output logic [15:0] stat_drop_count
`endif
);

  state_t      state_q;
  logic [7:0]  opcode_q;
  logic        pkt_done_q;
  logic        hdr_done_q;
  logic        data_done_q;
  logic        rsp_stats;
  logic        op_ok;
  logic        hdr_fire;
  logic        data_last;
  logic        hdr_ok;
  logic        data_ok;
  logic        start;
  logic [31:0] stats_word;
  logic        unused_len;

`ifdef UDP_RESPONDER_STATS_EN
  logic [15:0] disc_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        drop_evt;
  logic        disc_evt;

  assign op_ok = (rx_data == OP_DISCOVER) || (rx_data == OP_STATS);
  assign stats_word = {disc_cnt_q, drop_cnt_q};
  assign stat_disc_count = disc_cnt_q;
  assign stat_drop_count = drop_cnt_q;

  assign drop_evt =
    (state_q == ST_IDLE && rx_cmd_valid &&
     rx_cmd_dst_port != LISTEN_PORT) ||
    (state_q == ST_OPCODE && rx_data_valid && !op_ok);
  assign disc_evt = state_q == ST_RSP && data_last && !rsp_stats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disc_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (disc_evt)
        disc_cnt_q <= disc_cnt_q + 16'd1;
      if (drop_evt)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  assign op_ok = rx_data == OP_DISCOVER;
  assign stats_word = '0;
`endif

  assign unused_len = ^rx_cmd_length;

  assign rsp_stats = opcode_q == OP_STATS;
  assign hdr_fire  = tx_cmd_valid && tx_cmd_ready;
  assign data_last = tx_data_valid && tx_data_ready && tx_data_last;
  assign hdr_ok    = hdr_done_q || hdr_fire;
  assign data_ok   = data_done_q || data_last;
  assign start     = state_q == ST_OPCODE && rx_data_valid && op_ok;

  // rx header is held until FLUSH, so it feeds the reply directly.
  assign tx_cmd_ip       = rx_cmd_ip;
  assign tx_cmd_src_port = rx_cmd_dst_port;
  assign tx_cmd_dst_port = rx_cmd_src_port;
  assign tx_cmd_length   = rsp_stats ? 16'd5 : 16'(NAME_LEN + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      pkt_done_q  <= 1'b0;
      hdr_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_cmd_valid) begin
            if (rx_cmd_dst_port == LISTEN_PORT) begin
              state_q <= ST_OPCODE;
            end else begin
              state_q    <= ST_FLUSH;
              pkt_done_q <= 1'b0;
            end
          end
        end
        ST_OPCODE: begin
          if (rx_data_valid) begin
            opcode_q   <= rx_data;
            pkt_done_q <= rx_data_last;
            if (op_ok) begin
              state_q     <= ST_RSP;
              hdr_done_q  <= 1'b0;
              data_done_q <= 1'b0;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_RSP: begin
          if (hdr_fire)
            hdr_done_q <= 1'b1;
          if (data_last)
            data_done_q <= 1'b1;
          if (hdr_ok && data_ok)
            state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (rx_cmd_valid && rx_cmd_ready)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_cmd_ready  = 1'b0;
    rx_data_ready = 1'b0;
    tx_cmd_valid  = 1'b0;
    tx_data_valid = 1'b0;
    unique case (state_q)
      ST_OPCODE: rx_data_ready = 1'b1;
      ST_RSP: begin
        tx_cmd_valid  = !hdr_done_q;
        tx_data_valid = !data_done_q;
      end
      ST_FLUSH: begin
        rx_data_ready = !pkt_done_q;
        rx_cmd_ready  = pkt_done_q ||
                        (rx_data_valid && rx_data_last);
      end
      default: ;
    endcase
  end

  udp_reply_serializer #(
    .NAME_LEN (NAME_LEN),
    .NAME     (NAME)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .active_i     (tx_data_valid),
    .ready_i      (tx_data_ready),
    .stats_i      (rsp_stats),
    .stats_word_i (stats_word),
    .data_o       (tx_data),
    .last_o       (tx_data_last)
  );

endmodule

// File: tb/tb_udp_discovery_responder.sv
// Directed bench for udp_discovery_responder (default and
// UDP_RESPONDER_STATS_EN builds).
module tb_udp_discovery_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_cmd_valid, rx_cmd_ready;
  logic [31:0] rx_cmd_ip;
  logic [15:0] rx_cmd_src_port, rx_cmd_dst_port, rx_cmd_length;
  logic        rx_data_valid, rx_data_ready, rx_data_last;
  logic [7:0]  rx_data;
  logic        tx_cmd_valid, tx_cmd_ready;
  logic [31:0] tx_cmd_ip;
  logic [15:0] tx_cmd_src_port, tx_cmd_dst_port, tx_cmd_length;
  logic        tx_data_valid, tx_data_ready, tx_data_last;
  logic [7:0]  tx_data;
`ifdef UDP_RESPONDER_STATS_EN
  logic [15:0] stat_disc_count, stat_drop_count;
  localparam logic [1:0] K_STATS = 2'd2;
`else
  localparam logic [1:0] K_STATS = 2'd0;
`endif

  always #5 clk = ~clk;

  udp_discovery_responder dut (
    .clk             (clk),
    .reset           (reset),
    .rx_cmd_valid    (rx_cmd_valid),
    .rx_cmd_ready    (rx_cmd_ready),
    .rx_cmd_ip       (rx_cmd_ip),
    .rx_cmd_src_port (rx_cmd_src_port),
    .rx_cmd_dst_port (rx_cmd_dst_port),
    .rx_cmd_length   (rx_cmd_length),
    .rx_data_valid   (rx_data_valid),
    .rx_data_ready   (rx_data_ready),
    .rx_data_last    (rx_data_last),
    .rx_data         (rx_data),
    .tx_cmd_valid    (tx_cmd_valid),
    .tx_cmd_ready    (tx_cmd_ready),
    .tx_cmd_ip       (tx_cmd_ip),
    .tx_cmd_src_port (tx_cmd_src_port),
    .tx_cmd_dst_port (tx_cmd_dst_port),
    .tx_cmd_length   (tx_cmd_length),
    .tx_data_valid   (tx_data_valid),
    .tx_data_ready   (tx_data_ready),
    .tx_data_last    (tx_data_last),
    .tx_data         (tx_data)
`ifdef UDP_RESPONDER_STATS_EN
    ,
    .stat_disc_count (stat_disc_count),
    .stat_drop_count (stat_drop_count)
`endif
  );

  // kind: 0 = dropped, 1 = discover reply, 2 = stats reply
  typedef struct packed {
    logic [15:0] dport;
    logic [1:0]  len;
    logic [23:0] pl;
    logic [4:0]  hdr_dly;
    logic [1:0]  kind;
  } vec_t;

  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_disc = 16'd0;
  logic [15:0] m_drop = 16'd0;
  logic [7:0]  name_b [8] = '{8'h74, 8'h65, 8'h73, 8'h74,
                              8'h31, 8'h32, 8'h33, 8'h34};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          len, didx, nhdr, ntx, nlast, last_pos, nexp;
    int          hdr_cyc, last_tx_cyc, rx_last_cyc, cons_cyc;
    logic        done;
    logic [23:0] sh;
    logic [7:0]  txb [16];
    logic [7:0]  exp_b [16];
    logic [31:0] hip;
    logic [15:0] hs, hd, hl;
    len = int'(v.len);
    didx = 0; nhdr = 0; ntx = 0; nlast = 0; last_pos = -1;
    hdr_cyc = -1; last_tx_cyc = -1; rx_last_cyc = -1; cons_cyc = -1;
    done = 1'b0; hip = '0; hs = '0; hd = '0; hl = '0;
    nexp = 0;
    if (v.kind == 2'd1) begin
      nexp = 9;
      exp_b[0] = 8'h22;
      for (int k = 0; k < 8; k++) exp_b[k+1] = name_b[k];
    end else if (v.kind == 2'd2) begin
      nexp = 5;
      exp_b[0] = 8'h33;
      exp_b[1] = m_disc[15:8];
      exp_b[2] = m_disc[7:0];
      exp_b[3] = m_drop[15:8];
      exp_b[4] = m_drop[7:0];
    end
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      rx_cmd_valid    = 1'b1;
      rx_cmd_ip       = 32'hC0A8_0100 + 32'(id);
      rx_cmd_src_port = 16'h4000 + 16'(id);
      rx_cmd_dst_port = v.dport;
      rx_cmd_length   = 16'(8 + len);
      sh              = v.pl << (8 * didx);
      rx_data_valid   = didx < len;
      rx_data         = sh[23:16];
      rx_data_last    = didx == len - 1;
      tx_cmd_ready    = cyc >= int'(v.hdr_dly);
      tx_data_ready   = 1'b1;
      #1;
      if (tx_cmd_valid && tx_cmd_ready) begin
        nhdr++;
        hdr_cyc = cyc;
        hip = tx_cmd_ip; hs = tx_cmd_src_port;
        hd = tx_cmd_dst_port; hl = tx_cmd_length;
      end
      if (tx_data_valid && tx_data_ready) begin
        if (ntx < 16) txb[ntx] = tx_data;
        if (tx_data_last) begin
          nlast++; last_pos = ntx; last_tx_cyc = cyc;
        end
        ntx++;
      end
      if (rx_data_valid && rx_data_ready) begin
        didx++;
        if (didx == len) rx_last_cyc = cyc;
      end
      if (rx_cmd_valid && rx_cmd_ready) begin
        done = 1'b1; cons_cyc = cyc;
      end
    end
    @(negedge clk);
    rx_cmd_valid = 1'b0; rx_data_valid = 1'b0;
    rx_data_last = 1'b0; tx_cmd_ready = 1'b0;
    chk($sformatf("v%0d_cmd_consumed", id), done, 1);
    chk($sformatf("v%0d_rx_bytes", id), didx, len);
    chk($sformatf("v%0d_hdr_count", id), nhdr, v.kind != 0);
    chk($sformatf("v%0d_tx_count", id), ntx, nexp);
    if (v.kind != 2'd0) begin
      chk($sformatf("v%0d_hdr_ip", id), hip, 32'hC0A8_0100 + 32'(id));
      chk($sformatf("v%0d_hdr_src", id), hs, v.dport);
      chk($sformatf("v%0d_hdr_dst", id), hd, 16'h4000 + 16'(id));
      chk($sformatf("v%0d_hdr_len", id), hl, nexp);
      for (int k = 0; k < nexp && k < ntx; k++)
        chk($sformatf("v%0d_byte%0d", id, k), txb[k], exp_b[k]);
      chk($sformatf("v%0d_last_cnt", id), nlast, 1);
      chk($sformatf("v%0d_last_pos", id), last_pos, nexp - 1);
    end
    if (v.dport != 16'h9460 || len > 1)
      chk($sformatf("v%0d_cmd_with_last", id), cons_cyc, rx_last_cyc);
    else
      chk($sformatf("v%0d_cmd_after_data", id),
          cons_cyc > rx_last_cyc, 1);
    if (v.kind != 2'd0 && len == 1)
      chk($sformatf("v%0d_exit_cycle", id), cons_cyc,
          ((hdr_cyc > last_tx_cyc) ? hdr_cyc : last_tx_cyc) + 1);
    if (v.hdr_dly != 5'd0)
      chk($sformatf("v%0d_data_before_hdr", id),
          last_tx_cyc < hdr_cyc, 1);
    if (v.kind == 2'd0) m_drop = m_drop + 16'd1;
    if (v.kind == 2'd1) m_disc = m_disc + 16'd1;
`ifdef UDP_RESPONDER_STATS_EN
    chk($sformatf("v%0d_stat_disc", id), stat_disc_count, m_disc);
    chk($sformatf("v%0d_stat_drop", id), stat_drop_count, m_drop);
`endif
  endtask

  initial begin
    logic reached, sent;
    int   n;
    vecs[0] = '{dport:16'h9460, len:2'd1, pl:24'h110000,
                hdr_dly:5'd0, kind:2'd1};
    vecs[1] = '{dport:16'h1234, len:2'd3, pl:24'h010203,
                hdr_dly:5'd0, kind:2'd0};
    vecs[2] = '{dport:16'h9460, len:2'd3, pl:24'h11AABB,
                hdr_dly:5'd0, kind:2'd1};
    vecs[3] = '{dport:16'h9460, len:2'd1, pl:24'h130000,
                hdr_dly:5'd0, kind:K_STATS};
    vecs[4] = '{dport:16'h9460, len:2'd1, pl:24'h110000,
                hdr_dly:5'd20, kind:2'd1};
    vecs[5] = '{dport:16'h9460, len:2'd2, pl:24'h550100,
                hdr_dly:5'd0, kind:2'd0};
    vecs[6] = '{dport:16'h9460, len:2'd1, pl:24'h130000,
                hdr_dly:5'd0, kind:K_STATS};

    reset = 1'b1;
    rx_cmd_valid = 1'b0; rx_cmd_ip = '0; rx_cmd_src_port = '0;
    rx_cmd_dst_port = '0; rx_cmd_length = '0;
    rx_data_valid = 1'b0; rx_data_last = 1'b0; rx_data = '0;
    tx_cmd_ready = 1'b0; tx_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_cmd_valid", tx_cmd_valid, 0);
    chk("rst_tx_data_valid", tx_data_valid, 0);
    chk("rst_rx_cmd_ready", rx_cmd_ready, 0);
    chk("rst_rx_data_ready", rx_data_ready, 0);
`ifdef UDP_RESPONDER_STATS_EN
    chk("rst_disc", stat_disc_count, 0);
    chk("rst_drop", stat_drop_count, 0);
`endif
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_rx_data_ready", rx_data_ready, 0);
    chk("idle_tx_cmd_valid", tx_cmd_valid, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset while reply byte 4 is on the bus.
    reached = 1'b0; sent = 1'b0; n = 0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      rx_cmd_valid = 1'b1; rx_cmd_dst_port = 16'h9460;
      rx_cmd_src_port = 16'h5555; rx_cmd_ip = 32'h0A00_0001;
      rx_data_valid = !sent; rx_data = 8'h11; rx_data_last = 1'b1;
      tx_cmd_ready = 1'b1; tx_data_ready = 1'b1;
      #1;
      if (rx_data_valid && rx_data_ready) sent = 1'b1;
      if (tx_data_valid && n == 4) reached = 1'b1;
      else if (tx_data_valid && tx_data_ready) n++;
    end
    chk("rstmid_reached", reached, 1);
    chk("rstmid_byte4", tx_data, 8'h74);
    reset = 1'b1;
    rx_cmd_valid = 1'b0; rx_data_valid = 1'b0; rx_data_last = 1'b0;
    #1;
    chk("rstmid_tx_data_valid", tx_data_valid, 0);
    chk("rstmid_tx_cmd_valid", tx_cmd_valid, 0);
    chk("rstmid_rx_cmd_ready", rx_cmd_ready, 0);
`ifdef UDP_RESPONDER_STATS_EN
    chk("rstmid_disc", stat_disc_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tx_cmd_ready = 1'b0;
    m_disc = 16'd0; m_drop = 16'd0;
    run_vec(7, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
